btn_sched: RTL and testbench
============================

BTN_SCHED -- requirements
Module: btn_sched

Interface
REQ-001 SHALL have parameter NUM_BTN, default 4, number of button channels (2..8).
REQ-002 SHALL have parameter TICK_DIV, default 400000, clk cycles per sample tick (4 ms at 100 MHz); TICK_DIV >= NUM_BTN+2.
REQ-003 SHALL have parameter STABLE_CNT, default 3, consecutive differing samples needed to flip a channel's stable level.
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port btn  input  NUM_BTN  raw asynchronous button levels.
REQ-007 SHALL have port level  output  NUM_BTN  debounced stable level per channel.
REQ-008 SHALL have port evt_valid  output  1  press event offered.
REQ-009 SHALL have port evt_id  output  clog2(NUM_BTN)  channel index of offered event.
REQ-010 SHALL have port evt_ready  input  1  consumer accepts event.
REQ-011 SHALL have port evt_drop  output  1  sticky flag, a press was lost.
REQ-012 SHALL have port busy  output  1  high while a sample scan is in progress.

Function
REQ-013 SHALL pass each btn bit through a 2-flop synchronizer; only synchronized values are sampled.
REQ-014 SHALL run one shared divider 0..TICK_DIV-1; tick asserts one cycle when the divider wraps.
REQ-015 SHALL use FSM IDLE -> SCAN on tick; SCAN visits channel 0..NUM_BTN-1, one per cycle; SCAN -> IDLE after channel NUM_BTN-1; busy = (state==SCAN).
REQ-016 SHALL, on visiting a channel, increment its count if sample != level, else clear count; count saturates at STABLE_CNT.
REQ-017 SHALL, when count reaches STABLE_CNT on a visit, toggle level in that cycle and clear count.
REQ-018 SHALL set the channel's pending flag on a 0->1 level toggle only; 1->0 produces no event.
REQ-019 SHALL, if pending is already set when a new press arrives, keep pending and set evt_drop (sticky until reset).
REQ-020 SHALL, if pending clears by handshake in the same cycle a new press sets it, leave pending set, no drop.
REQ-021 SHALL assert evt_valid whenever any pending flag is set; evt_id selects round-robin: first pending index after last-granted index, wrapping.
REQ-022 SHALL hold evt_valid and evt_id stable until evt_valid & evt_ready; transfer clears that pending bit and updates last-granted next cycle.
REQ-023 SHALL allow back-to-back transfers, one per cycle, with evt_ready held high.
REQ-024 SHALL make evt_valid registered; new pending visible on evt_valid one cycle after the toggle.

Reset
REQ-025 SHALL, with rst_n low at a clk edge, clear divider, FSM to IDLE, counts, level, pending, evt_valid, evt_id, evt_drop, busy to 0; last-granted to NUM_BTN-1.
REQ-026 SHALL abort a scan in progress on reset; no partial events after release.
REQ-027 SHALL hold synchronizer flops at 0 during reset.

Configuration
REQ-028 SHALL, with BTN_SCHED_REPEAT_EN defined, re-set pending for a channel held level 1 after 125 ticks (500 ms), then every 25 ticks (100 ms), repeat counter cleared on level 0.
REQ-029 SHALL, without BTN_SCHED_REPEAT_EN, emit exactly one event per press and contain no repeat counters.

Structure
REQ-030 SHALL place FSM state encoding and default TICK_DIV/STABLE_CNT/repeat constants in shared package btn_pkg.
REQ-031 SHALL implement the round-robin selector as sub-module rr_pick (NUM_BTN-bit request, last index in; index, valid out).

Verification (TICK_DIV=16, STABLE_CNT=3, NUM_BTN=4 bench)
REQ-032 SHALL test: btn[2] 0->1 held, evt_ready=1 -> level[2] rises on 3rd tick visit, single event id=2, evt_drop=0.
REQ-033 SHALL test: btn[1] glitches high for 2 ticks -> no level change, no event.
REQ-034 SHALL test: btn[0],btn[3] pressed same tick, evt_ready=0 for 50 cycles then 1 -> ids 0 then 3 on consecutive cycles, evt_id stable while stalled.
REQ-035 SHALL test: btn[1] pressed, released, pressed again with evt_ready=0 -> one event id=1, evt_drop=1.
REQ-036 SHALL test: rst_n low mid-SCAN with counts nonzero -> all outputs 0 next cycle, first event only after full STABLE_CNT ticks.
REQ-037 SHALL test with BTN_SCHED_REPEAT_EN: btn[0] held 200 ticks -> events at press, +125, +150, +175, +200 ticks.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared constants and types for the button scheduler.
// The optional auto-repeat feature is enabled with BTN_SCHED_REPEAT_EN.
package btn_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

    localparam int DEF_TICK_DIV   = 400000;
    localparam int DEF_STABLE_CNT = 3;

    // Auto-repeat timing, in sample ticks: first repeat, then the period.
    localparam int REP_FIRST = 125;
    localparam int REP_NEXT  = 25;
    localparam int REP_W     = 7;

endpackage

// File: rtl/btn_sched_if.sv
// Press-event handshake between the scheduler (master) and its consumer.
interface btn_sched_if #(
    parameter int NUM_BTN = 4,
    parameter int ID_W    = $clog2(NUM_BTN)
);
    logic            evt_valid;
    logic [ID_W-1:0] evt_id;
    logic            evt_ready;
    logic            evt_drop;

    modport master (output evt_valid, output evt_id, output evt_drop, input evt_ready);
    modport slave  (input evt_valid, input evt_id, input evt_drop, output evt_ready);
endinterface

// File: rtl/btn_sched_rr_pick.sv
// Round-robin picker: first set request strictly after 'last', wrapping.
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] idx,
    output logic         valid
);
    logic hit;

    // Scan requests starting just after the last grant; keep the first hit.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        hit   = 1'b0;
        for (int k = 1; k <= N; k++) begin
            hit   = !valid && req[(int'(last) + k) % N];
            idx   = hit ? W'((int'(last) + k) % N) : idx;
            valid = valid | hit;
        end
    end
endmodule

// File: rtl/btn_sched.sv
// Debounced multi-button sampler with round-robin press-event delivery.
// Define BTN_SCHED_REPEAT_EN to add auto-repeat for held buttons.
module btn_sched
    import btn_pkg::*;
#(
    parameter int NUM_BTN    = 4,
    parameter int TICK_DIV   = DEF_TICK_DIV,
    parameter int STABLE_CNT = DEF_STABLE_CNT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn,
    output logic [NUM_BTN-1:0] level,
    output logic               busy,
    btn_sched_if.master        evt
);
    localparam int ID_W  = $clog2(NUM_BTN);
    localparam int DIV_W = $clog2(TICK_DIV);
    localparam int CNT_W = $clog2(STABLE_CNT + 1);

    logic [NUM_BTN-1:0] sync1_q, sync2_q;
    logic [DIV_W-1:0]   div_q, div_d;
    state_e             state_q, state_d;
    logic [ID_W-1:0]    chan_q, chan_d;
    logic [CNT_W-1:0]   cnt_q [NUM_BTN];
    logic [CNT_W-1:0]   cnt_d [NUM_BTN];
    logic [NUM_BTN-1:0] level_q, level_d;
    logic [NUM_BTN-1:0] pend_q, pend_d;
    logic               drop_q, drop_d;
    logic               valid_q, valid_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ID_W-1:0]    last_q, last_d;
`ifdef BTN_SCHED_REPEAT_EN
    logic [REP_W-1:0]   rep_q [NUM_BTN];
    logic [REP_W-1:0]   rep_d [NUM_BTN];
`endif

    logic               tick_s, fire_s;
    logic [NUM_BTN-1:0] visit_s, press_s, clr_s;
    logic [ID_W-1:0]    pick_idx_s;
    logic               pick_vld_s;

    assign tick_s        = (div_q == DIV_W'(TICK_DIV - 1));
    assign level         = level_q;
    assign busy          = (state_q == ST_SCAN);
    assign evt.evt_valid = valid_q;
    assign evt.evt_id    = id_q;
    assign evt.evt_drop  = drop_q;

    // Tick divider and scan FSM next-state: one channel visited per cycle.
    always_comb begin
        div_d   = tick_s ? '0 : div_q + DIV_W'(1);
        state_d = state_q;
        chan_d  = chan_q;
        case (state_q)
            ST_IDLE: begin
                if (tick_s) begin
                    state_d = ST_SCAN;
                    chan_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (chan_q == ID_W'(NUM_BTN - 1)) begin
                    state_d = ST_IDLE;
                    chan_d  = '0;
                end else begin
                    chan_d = chan_q + ID_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                chan_d  = '0;
            end
        endcase
    end

    // Per-channel debounce on visit; a 0->1 level flip (or repeat) is a press.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        press_s = '0;
        visit_s = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            visit_s[i] = (state_q == ST_SCAN) && (chan_q == ID_W'(i));
            if (visit_s[i]) begin
                if (sync2_q[i] != level_q[i]) begin
                    if (cnt_q[i] == CNT_W'(STABLE_CNT - 1)) begin
                        level_d[i] = ~level_q[i];
                        cnt_d[i]   = '0;
                        press_s[i] = ~level_q[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end else begin
                    cnt_d[i] = '0;
                end
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
`ifdef BTN_SCHED_REPEAT_EN
        rep_d = rep_q;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (visit_s[i] && level_q[i] && level_d[i]) begin
                if (rep_q[i] == REP_W'(REP_FIRST - 1)) begin
                    rep_d[i]   = REP_W'(REP_FIRST - REP_NEXT);
                    press_s[i] = 1'b1;
                end else begin
                    rep_d[i] = rep_q[i] + REP_W'(1);
                end
            end else if (!level_d[i]) begin
                rep_d[i] = '0;
            end else begin
                rep_d[i] = rep_q[i];
            end
        end
`endif
    end

    // Pending flags: handshake clears, presses set; a press on a still-set flag is lost.
    always_comb begin
        fire_s    = valid_q & evt.evt_ready;
        clr_s     = '0;
        clr_s[id_q] = fire_s;
        pend_d    = (pend_q & ~clr_s) | press_s;
        drop_d    = drop_q | (|(press_s & pend_q & ~clr_s));
        last_d    = fire_s ? id_q : last_q;
    end

    rr_pick #(.N(NUM_BTN), .W(ID_W)) u_rr_pick (
        .req   (pend_d),
        .last  (last_d),
        .idx   (pick_idx_s),
        .valid (pick_vld_s)
    );

    // Offered event is frozen while stalled, otherwise re-picked from next pending.
    always_comb begin
        if (valid_q && !fire_s) begin
            valid_d = valid_q;
            id_d    = id_q;
        end else begin
            valid_d = pick_vld_s;
            id_d    = pick_idx_s;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            div_q   <= '0;
            state_q <= ST_IDLE;
            chan_q  <= '0;
            level_q <= '0;
            pend_q  <= '0;
            drop_q  <= 1'b0;
            valid_q <= 1'b0;
            id_q    <= '0;
            last_q  <= ID_W'(NUM_BTN - 1);
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt_q[i] <= '0;
`ifdef BTN_SCHED_REPEAT_EN
                rep_q[i] <= '0;
`endif
            end
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            div_q   <= div_d;
            state_q <= state_d;
            chan_q  <= chan_d;
            level_q <= level_d;
            pend_q  <= pend_d;
            drop_q  <= drop_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
`ifdef BTN_SCHED_REPEAT_EN
            rep_q   <= rep_d;
`endif
        end
    end
endmodule

// File: tb/tb_btn_sched.sv
// Directed bench for btn_sched (NUM_BTN=4, TICK_DIV=16, STABLE_CNT=3).
module tb_btn_sched;
    localparam int NB = 4;
    localparam int TD = 16;
    localparam int SC = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] btn = '0;
    logic [NB-1:0] level;
    logic          busy;

    btn_sched_if #(.NUM_BTN(NB)) eif ();

    btn_sched #(.NUM_BTN(NB), .TICK_DIV(TD), .STABLE_CNT(SC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn),
        .level (level),
        .busy  (busy),
        .evt   (eif.master)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic [1:0] ev_id [$];
    int         ev_cyc [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Record every accepted event (valid & ready seen before the next edge).
    always @(negedge clk) begin
        if (rst_n && eif.evt_valid && eif.evt_ready) begin
            ev_id.push_back(eif.evt_id);
            ev_cyc.push_back(cyc);
        end
    end

    typedef struct {
        logic [NB-1:0] btn;
        int            hold;
        logic          ready;
        int            exp_evts;
        logic [1:0]    exp_id0;
        logic [NB-1:0] exp_level;
        logic          exp_drop;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        step(n * TD);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        btn = '0;
        eif.evt_ready = 1'b0;
        step(3);
        rst_n = 1'b1;
        ev_id.delete();
        ev_cyc.delete();
    endtask

    task automatic wait_busy(input logic val, input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (busy !== val && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy !== val) begin
            checks++;
            failures++;
            $display("FAIL %s timeout waiting busy=%0d", nm, val);
        end
    endtask

    task automatic wait_scan_end(input string nm);
        wait_busy(1'b1, nm);
        wait_busy(1'b0, nm);
    endtask

    vec_t vt [5];

    initial begin
        int bad;
        eif.evt_ready = 1'b0;

        vt[0] = '{btn: 4'b0100, hold: 6, ready: 1'b1, exp_evts: 1, exp_id0: 2'd2, exp_level: 4'b0100, exp_drop: 1'b0};
        vt[1] = '{btn: 4'b0010, hold: 2, ready: 1'b1, exp_evts: 0, exp_id0: 2'd0, exp_level: 4'b0000, exp_drop: 1'b0};
        vt[2] = '{btn: 4'b1001, hold: 6, ready: 1'b1, exp_evts: 2, exp_id0: 2'd0, exp_level: 4'b1001, exp_drop: 1'b0};
        vt[3] = '{btn: 4'b1111, hold: 6, ready: 1'b1, exp_evts: 4, exp_id0: 2'd0, exp_level: 4'b1111, exp_drop: 1'b0};
        vt[4] = '{btn: 4'b0000, hold: 6, ready: 1'b1, exp_evts: 0, exp_id0: 2'd0, exp_level: 4'b0000, exp_drop: 1'b0};

        // Reset state.
        do_reset();
        @(negedge clk);
        chk("rst_level", int'(level), 0);
        chk("rst_valid", int'(eif.evt_valid), 0);
        chk("rst_drop", int'(eif.evt_drop), 0);
        chk("rst_busy", int'(busy), 0);

        // Table: press pattern, hold, release; count events afterwards.
        for (int i = 0; i < 5; i++) begin
            do_reset();
            eif.evt_ready = vt[i].ready;
            btn = vt[i].btn;
            ticks(vt[i].hold);
            @(negedge clk);
            chk($sformatf("v%0d_level_held", i), int'(level), int'(vt[i].exp_level));
            step(1);
            btn = '0;
            ticks(6);
            @(negedge clk);
            chk($sformatf("v%0d_evts", i), ev_id.size(), vt[i].exp_evts);
            if (vt[i].exp_evts > 0)
                chk($sformatf("v%0d_id0", i), int'(ev_id[0]), int'(vt[i].exp_id0));
            chk($sformatf("v%0d_drop", i), int'(eif.evt_drop), int'(vt[i].exp_drop));
            chk($sformatf("v%0d_level_rel", i), int'(level), 0);
        end

        // Two simultaneous presses, consumer stalled 50 cycles.
        do_reset();
        btn = 4'b1001;
        ticks(6);
        @(negedge clk);
        chk("stall_valid", int'(eif.evt_valid), 1);
        chk("stall_id", int'(eif.evt_id), 0);
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (eif.evt_valid !== 1'b1 || eif.evt_id !== 2'd0) bad++;
        end
        chk("stall_stable_cycles_bad", bad, 0);
        @(posedge clk);
        #1;
        eif.evt_ready = 1'b1;
        step(4);
        @(negedge clk);
        chk("stall_evts", ev_id.size(), 2);
        chk("stall_first", int'(ev_id[0]), 0);
        chk("stall_second", int'(ev_id[1]), 3);
        chk("stall_gap", ev_cyc[1] - ev_cyc[0], 1);
        chk("stall_valid_after", int'(eif.evt_valid), 0);

        // Press, release, press again while the first is still pending.
        do_reset();
        btn = 4'b0010;
        ticks(5);
        btn = 4'b0000;
        ticks(5);
        btn = 4'b0010;
        ticks(5);
        @(negedge clk);
        chk("drop_flag", int'(eif.evt_drop), 1);
        chk("drop_valid", int'(eif.evt_valid), 1);
        chk("drop_id", int'(eif.evt_id), 1);
        @(posedge clk);
        #1;
        eif.evt_ready = 1'b1;
        step(5);
        @(negedge clk);
        chk("drop_evts", ev_id.size(), 1);
        chk("drop_sticky", int'(eif.evt_drop), 1);

        // Reset in the middle of a scan with a partial count on channel 2.
        do_reset();
        eif.evt_ready = 1'b1;
        btn = 4'b0100;
        wait_scan_end("mid_scan_a");
        wait_scan_end("mid_scan_b");
        wait_busy(1'b1, "mid_scan_c");
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_level", int'(level), 0);
        chk("mid_rst_valid", int'(eif.evt_valid), 0);
        chk("mid_rst_id", int'(eif.evt_id), 0);
        chk("mid_rst_drop", int'(eif.evt_drop), 0);
        #1 rst_n = 1'b1;
        ev_id.delete();
        ev_cyc.delete();
        wait_scan_end("post_rst_1");
        wait_scan_end("post_rst_2");
        chk("post_rst_level_2scans", int'(level), 0);
        chk("post_rst_evts_2scans", ev_id.size(), 0);
        wait_scan_end("post_rst_3");
        chk("post_rst_level_3scans", int'(level), 4);
        step(3);
        @(negedge clk);
        chk("post_rst_evts", ev_id.size(), 1);
        chk("post_rst_id", int'(ev_id[0]), 2);

`ifdef BTN_SCHED_REPEAT_EN
        // Held button: initial press plus repeats at +125, +150, +175, +200 ticks.
        do_reset();
        eif.evt_ready = 1'b1;
        btn = 4'b0001;
        ticks(212);
        btn = 4'b0000;
        ticks(6);
        @(negedge clk);
        chk("rep_evts", ev_id.size(), 5);
        if (ev_id.size() == 5) begin
            chk("rep_first_gap", ev_cyc[1] - ev_cyc[0], 125 * TD);
            for (int k = 2; k < 5; k++)
                chk($sformatf("rep_gap%0d", k), ev_cyc[k] - ev_cyc[k-1], 25 * TD);
        end
        chk("rep_drop", int'(eif.evt_drop), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
